// File: rtl/pipelined_shift_unit.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR), one register stage per mux level.
// Optional feature macro: SHIFT_ROTATE_EN (mode 11 = ROR; otherwise mode 11 acts as LSR).
module pipelined_shift_unit #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_operand,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam logic [1:0] M_LSL = 2'b00;
    localparam logic [1:0] M_LSR = 2'b01;
    localparam logic [1:0] M_ASR = 2'b10;
    localparam logic [1:0] M_ROR = 2'b11;
    localparam logic [LEVELS-1:0] ONE_L = {{(LEVELS-1){1'b0}}, 1'b1};

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends on ready, and a held (unaccepted) output keeps all its fields stable.

    logic [LEVELS-1:0] valid_q;
    logic [WIDTH-1:0]  data_q  [LEVELS];
    logic [LEVELS-1:0] amt_q   [LEVELS];
    logic [1:0]        mode_q  [LEVELS];
    logic              carry_q [LEVELS];
    logic              sat_q   [LEVELS];
    logic [TAG_W-1:0]  tag_q   [LEVELS];

    logic [LEVELS-1:0] src_valid;
    logic [WIDTH-1:0]  src_data  [LEVELS];
    logic [LEVELS-1:0] src_amt   [LEVELS];
    logic [1:0]        src_mode  [LEVELS];
    logic              src_carry [LEVELS];
    logic              src_sat   [LEVELS];
    logic [TAG_W-1:0]  src_tag   [LEVELS];
    logic [WIDTH-1:0]  nxt_data  [LEVELS];
    logic [LEVELS-1:0] adv;

    logic [1:0]        eff_mode;
    logic              in_sat;
    logic              in_carry;
    logic              gt_w;
    logic [LEVELS-1:0] idx_l;
    logic [LEVELS-1:0] idx_r;

    function automatic logic [WIDTH-1:0] shift_lvl(input logic [WIDTH-1:0] p,
                                                   input logic [1:0] m, input int sh);
        case (m)
            M_LSL:   shift_lvl = p << sh;
            M_ASR:   shift_lvl = $signed(p) >>> sh;
`ifdef SHIFT_ROTATE_EN
            M_ROR:   shift_lvl = (p >> sh) | (p << (WIDTH - sh));
`endif
            default: shift_lvl = p >> sh;
        endcase
    endfunction

    // Carry is resolved once at the input from the full amount and travels with the op.
    always_comb begin
        eff_mode = in_mode;
`ifndef SHIFT_ROTATE_EN
        if (in_mode == M_ROR) eff_mode = M_LSR;
`endif
        in_sat = |in_amt[AMT_W-1:LEVELS];
        gt_w   = in_amt > AMT_W'(WIDTH);
        idx_l  = -in_amt[LEVELS-1:0];
        idx_r  = in_amt[LEVELS-1:0] - ONE_L;
        in_carry = 1'b0;
        case (eff_mode)
            M_LSL:   in_carry = gt_w ? 1'b0 : in_operand[idx_l];
            M_LSR:   in_carry = gt_w ? 1'b0 : in_operand[idx_r];
            M_ASR:   in_carry = gt_w ? in_operand[WIDTH-1] : in_operand[idx_r];
            default: in_carry = in_operand[idx_r];
        endcase
        if (in_amt == '0) in_carry = 1'b0;
    end

    always_comb begin
        src_valid = {valid_q[LEVELS-2:0], in_valid};
        src_data[0]  = in_operand;
        src_amt[0]   = in_amt[LEVELS-1:0];
        src_mode[0]  = eff_mode;
        src_carry[0] = in_carry;
        src_sat[0]   = in_sat;
        src_tag[0]   = in_tag;
        for (int s = 1; s < LEVELS; s++) begin
            src_data[s]  = data_q[s-1];
            src_amt[s]   = amt_q[s-1];
            src_mode[s]  = mode_q[s-1];
            src_carry[s] = carry_q[s-1];
            src_sat[s]   = sat_q[s-1];
            src_tag[s]   = tag_q[s-1];
        end
    end

    // Saturation is folded into the last level; ASR keeps the operand MSB in bit WIDTH-1 throughout.
    always_comb begin
        for (int s = 0; s < LEVELS; s++) begin
            nxt_data[s] = src_data[s];
            if (src_amt[s][s]) nxt_data[s] = shift_lvl(src_data[s], src_mode[s], 1 << s);
            if (s == LEVELS - 1 && src_sat[s] && src_mode[s] != M_ROR)
                nxt_data[s] = {WIDTH{(src_mode[s] == M_ASR) & src_data[s][WIDTH-1]}};
        end
    end

    always_comb begin
        adv = '0;
        adv[LEVELS-1] = !valid_q[LEVELS-1] || out_ready;
        for (int s = LEVELS - 2; s >= 0; s--)
            adv[s] = !valid_q[s] || adv[s+1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int s = 0; s < LEVELS; s++) begin
                data_q[s]  <= '0;
                amt_q[s]   <= '0;
                mode_q[s]  <= '0;
                carry_q[s] <= 1'b0;
                sat_q[s]   <= 1'b0;
                tag_q[s]   <= '0;
            end
        end else begin
            for (int s = 0; s < LEVELS; s++) begin
                if (adv[s]) begin
                    valid_q[s] <= src_valid[s];
                    if (src_valid[s]) begin
                        data_q[s]  <= nxt_data[s];
                        amt_q[s]   <= src_amt[s];
                        mode_q[s]  <= src_mode[s];
                        carry_q[s] <= src_carry[s];
                        sat_q[s]   <= src_sat[s];
                        tag_q[s]   <= src_tag[s];
                    end
                end
            end
        end
    end

    assign in_ready   = !valid_q[0] || adv[0];
    assign out_valid  = valid_q[LEVELS-1];
    assign out_result = data_q[LEVELS-1];
    assign out_carry  = carry_q[LEVELS-1];
    assign out_tag    = tag_q[LEVELS-1];

endmodule
